// File: rtl/dmux_router_if.sv
// -----------------------------------------------------------------------------
// dmux_router_if
//
// Purpose: bundles the producer-side word stream and the W consumer-side
// channels of dmux_router into one interface.
//
// Parameters:
//   W  number of output channels (power of two, >= 2)
//   N  data word width in bits
//
// Signals:
//   in_data   [N-1:0]          word offered by the producer
//   in_dest   [$clog2(W)-1:0]  destination channel index of in_data
//   in_valid                   producer has a word
//   in_ready                   router accepts the word this cycle
//   out_data  [W*N-1:0]        packed channel registers, slot 0 in the MSBs
//   out_valid [W-1:0]          channel k valid on bit W-1-k
//   out_ready [W-1:0]          consumer k ready on bit W-1-k
//
// Modports:
//   master  the environment (producer plus consumers)
//   slave   the router itself
// -----------------------------------------------------------------------------
interface dmux_router_if #(
  parameter int W = 2,
  parameter int N = 1
);
  localparam int DW = $clog2(W);

  logic [N-1:0]   in_data;
  logic [DW-1:0]  in_dest;
  logic           in_valid;
  logic           in_ready;
  logic [W*N-1:0] out_data;
  logic [W-1:0]   out_valid;
  logic [W-1:0]   out_ready;

  modport master (
    output in_data, in_dest, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_dest, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/dmux_router.sv
// -----------------------------------------------------------------------------
// dmux_router
//
// Purpose: routes one handshaked word stream to W output channels. Each word
// carries a destination index; each channel has a one-entry holding register
// with its own valid/ready handshake, so a stalled channel only blocks words
// addressed to it.
//
// Parameters:
//   W  number of output channels (power of two, >= 2)
//   N  data word width in bits
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   bus           dmux_router_if.slave (input stream + W output channels)
//   accept_count  [15:0] words accepted since reset, wrapping; present only
//                 when the DMUX_ROUTER_STATS_EN macro is defined
// -----------------------------------------------------------------------------
module dmux_router #(
  parameter int W = 2,
  parameter int N = 1
) (
  input  logic               clk,
  input  logic               rst,
  dmux_router_if.slave       bus
`ifdef DMUX_ROUTER_STATS_EN
  ,
  output logic [15:0]        accept_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  // Internal arrays are indexed by channel number k; the reversed bit order
  // of the external vectors is handled only in the mapping below.
  chan_state_e  state_q [W];
  chan_state_e  state_d [W];
  logic [N-1:0] data_q  [W];
  logic [N-1:0] data_d  [W];

  logic [W-1:0] chan_ready;
  logic [W-1:0] chan_fire;
  logic         in_fire;

  for (genvar k = 0; k < W; k++) begin : g_chan
    assign chan_ready[k]                  = bus.out_ready[W-1-k];
    assign chan_fire[k]                   = (state_q[k] == FULL) & chan_ready[k];
    assign bus.out_valid[W-1-k]           = (state_q[k] == FULL);
    assign bus.out_data[(W-k)*N-1 -: N]   = data_q[k];
  end

  // A full channel can still take a word when its consumer drains it on the
  // same edge; this is what sustains one word per cycle per channel.
  assign bus.in_ready = (state_q[bus.in_dest] == EMPTY) | chan_ready[bus.in_dest];
  assign in_fire      = bus.in_valid & bus.in_ready;

  // NOTE: every variable assigned here gets its hold value first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int k = 0; k < W; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      if (in_fire && (int'(bus.in_dest) == k)) begin
        // Covers both EMPTY->FULL and the consume-and-reload FULL->FULL case.
        state_d[k] = FULL;
        data_d[k]  = bus.in_data;
      end else if (chan_fire[k]) begin
        state_d[k] = EMPTY;
      end
    end
  end

`ifdef DMUX_ROUTER_STATS_EN
  logic [15:0] accept_count_q;
  logic [15:0] accept_count_d;

  // Wraps naturally from 16'hFFFF to 0.
  assign accept_count_d = in_fire ? accept_count_q + 16'd1 : accept_count_q;
  assign accept_count   = accept_count_q;
`endif

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < W; k++) begin
        state_q[k] <= EMPTY;
        // NOTE: the data registers are reset too, because out_data must read
        // as zero after reset, not just be qualified invalid.
        data_q[k]  <= '0;
      end
`ifdef DMUX_ROUTER_STATS_EN
      accept_count_q <= '0;
`endif
    end else begin
      for (int k = 0; k < W; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
`ifdef DMUX_ROUTER_STATS_EN
      accept_count_q <= accept_count_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmux_router.sv
// -----------------------------------------------------------------------------
// tb_dmux_router
//
// Purpose: self-checking bench for dmux_router with W=4, N=8. A table of
// per-cycle vectors covers single delivery, stall/blocking, independent
// draining and reset overriding a handshake; hand-written sequences cover
// back-to-back streaming, reset with every channel full and, when
// DMUX_ROUTER_STATS_EN is defined, the accept counter wrap.
//
// Inputs are driven on the falling edge; in_ready is sampled 1 ns later and
// registered outputs 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_dmux_router;

  localparam int W = 4;
  localparam int N = 8;

  logic clk;
  logic rst;

  dmux_router_if #(.W(W), .N(N)) bus ();

`ifdef DMUX_ROUTER_STATS_EN
  logic [15:0] accept_count;
`endif

  dmux_router #(.W(W), .N(N)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave)
`ifdef DMUX_ROUTER_STATS_EN
    ,
    .accept_count (accept_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_dest;
    logic [7:0]  in_data;
    logic [3:0]  out_ready;
    logic        exp_ready;   // in_ready before the edge
    logic [3:0]  exp_valid;   // out_valid after the edge
    logic [31:0] exp_data;    // out_data after the edge
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] d,
                       input logic [7:0] data, input logic [3:0] ordy);
    rst           = r;
    bus.in_valid  = v;
    bus.in_dest   = d;
    bus.in_data   = data;
    bus.out_ready = ordy;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v.rst, v.in_valid, v.in_dest, v.in_data, v.out_ready);
    #1;
    check({v.name, ".in_ready"}, 32'(bus.in_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    check({v.name, ".out_valid"}, 32'(bus.out_valid), 32'(v.exp_valid));
    check({v.name, ".out_data"}, bus.out_data, v.exp_data);
  endtask

  vec_t vecs [12];

  initial begin
    // name, rst, valid, dest, data, out_ready, exp_ready, exp_valid, exp_data
    vecs[0]  = '{"reset_state",   1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000};
    vecs[1]  = '{"a5_dest0",      1'b0, 1'b1, 2'd0, 8'hA5, 4'b1111, 1'b1, 4'b1000, 32'hA500_0000};
    vecs[2]  = '{"a5_drained",    1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'hA500_0000};
    vecs[3]  = '{"stall_11",      1'b0, 1'b1, 2'd1, 8'h11, 4'b1011, 1'b1, 4'b0100, 32'hA511_0000};
    vecs[4]  = '{"stall_22_blk",  1'b0, 1'b1, 2'd1, 8'h22, 4'b1011, 1'b0, 4'b0100, 32'hA511_0000};
    vecs[5]  = '{"stall_33_d2",   1'b0, 1'b1, 2'd2, 8'h33, 4'b1011, 1'b1, 4'b0110, 32'hA511_3300};
    vecs[6]  = '{"drain_take_22", 1'b0, 1'b1, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0100, 32'hA522_3300};
    vecs[7]  = '{"idle_ignored",  1'b0, 1'b0, 2'd1, 8'hFF, 4'b1111, 1'b1, 4'b0000, 32'hA522_3300};
    vecs[8]  = '{"fill_ch3",      1'b0, 1'b1, 2'd3, 8'h5C, 4'b0000, 1'b1, 4'b0001, 32'hA522_335C};
    vecs[9]  = '{"rdy_no_valid",  1'b0, 1'b0, 2'd3, 8'h00, 4'b0000, 1'b0, 4'b0001, 32'hA522_335C};
    vecs[10] = '{"ch0_past_stall",1'b0, 1'b1, 2'd0, 8'h77, 4'b0000, 1'b1, 4'b1001, 32'h7722_335C};
    vecs[11] = '{"rst_beats_fire",1'b1, 1'b1, 2'd1, 8'hEE, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000};

    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 12; i++) apply(vecs[i]);

    // Back-to-back: 16 words to channel 3, each visible one cycle later.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 2'd3, 8'(8'h40 + i), 4'b1111);
      #1;
      check($sformatf("b2b_%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("b2b_%0d.out_valid", i), 32'(bus.out_valid), 32'(4'b0001));
      check($sformatf("b2b_%0d.slot3", i), 32'(bus.out_data[7:0]), 32'(8'h40 + i));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd3, 8'h00, 4'b1111);
    @(posedge clk);
    #1;
    check("b2b_end.out_valid", 32'(bus.out_valid), 32'(4'b0000));

    // Reset with every channel holding a word and no consumer ready.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 2'(i), 8'(8'hC0 + i), 4'b0000);
      #1;
      check($sformatf("fill_%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    #1;
    check("full_all.out_valid", 32'(bus.out_valid), 32'(4'b1111));
    check("full_all.out_data", bus.out_data, 32'hC0C1_C2C3);
    check("full_all.in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
    @(posedge clk);
    #1;
    check("mid_rst.out_valid", 32'(bus.out_valid), 32'(4'b0000));
    check("mid_rst.out_data", bus.out_data, 32'h0000_0000);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    @(posedge clk);
    #1;
    check("post_rst.out_valid", 32'(bus.out_valid), 32'(4'b0000));
    check("post_rst.out_data", bus.out_data, 32'h0000_0000);

`ifdef DMUX_ROUTER_STATS_EN
    check("stats_cleared", 32'(accept_count), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd0, 8'h99, 4'b1111);
    repeat (65537) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    #1;
    check("stats_wrap", 32'(accept_count), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
